// File: rtl/cache_mem_backing_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_backing_responder
// Purpose  : Backing-store responder for the cache miss/writeback path.
//            Accepts one single-word read or write at a time over a
//            valid/ready handshake. It answers after LATENCY cycles from a
//            local 32-bit word array. Words that have never been written
//            read back as 32'hDEADBEEF.
// Options  : CACHE_MEM_ERR_EN - adds rsp_err, which flags reads of
//            unwritten words.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_backing_responder #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 3   // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef CACHE_MEM_ERR_EN
  output logic              rsp_err,
`endif
  output logic [31:0]       rsp_rdata
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [31:0] FILL_WORD = 32'hDEADBEEF;
  // The counter is loaded with LATENCY-1 at acceptance. BUSY then runs
  // LATENCY cycles (counting down through zero), so rsp_valid rises after
  // edge N+LATENCY for every legal LATENCY, including 1.
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH-1:0]    written;
  logic                accept;
  logic                rsp_load;
  logic [31:0]         rd_word;

  assign accept   = req_valid & req_ready;
  assign rsp_load = (state == BUSY) && (cnt == 4'd0);
  assign rd_word  = written[addr_q] ? mem[addr_q] : FILL_WORD;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so nothing is accepted while rst is high.
        req_ready = ~rst;
        if (req_valid && !rst) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and response data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_LOAD;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (rsp_load) begin
        rsp_rdata <= write_q ? wdata_q : rd_word;
      end
    end
  end

  // Data array: deliberately not reset, so committed data survives a reset
  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      mem[req_addr] <= req_wdata;
    end
  end

  // Written-bits: cleared by reset, so pre-reset writes read as fill again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      written <= '0;
    end else if (accept && req_write) begin
      written[req_addr] <= 1'b1;
    end
  end

`ifdef CACHE_MEM_ERR_EN
  // Error flag for unwritten-word reads, held alongside rsp_rdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (rsp_load) begin
      rsp_err <= ~write_q & ~written[addr_q];
    end
  end
`endif

endmodule
`default_nettype wire
